// File: rtl/ls_usb_pkg.sv
// Shared constants for the low-speed USB receive path: PIDs, error codes,
// CRC polynomials and the packet controller state encoding.
package ls_usb_pkg;

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    // PID[1:0] selects the packet class
    localparam logic [1:0] PT_SPECIAL   = 2'b00;
    localparam logic [1:0] PT_TOKEN     = 2'b01;
    localparam logic [1:0] PT_HANDSHAKE = 2'b10;
    localparam logic [1:0] PT_DATA      = 2'b11;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_SYNC    = 3'd1,
        ERR_PID     = 3'd2,
        ERR_CRC     = 3'd3,
        ERR_LEN     = 3'd4,
        ERR_UNSUP   = 3'd5,
        ERR_OVERRUN = 3'd6
    } err_e;

    localparam logic [4:0]  CRC5_POLY   = 5'h05;
    localparam logic [4:0]  CRC5_INIT   = 5'h1F;
    localparam logic [4:0]  CRC5_RESID  = 5'b01100;
    localparam logic [15:0] CRC16_POLY  = 16'h8005;
    localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
    localparam logic [15:0] CRC16_RESID = 16'h800D;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PID  = 3'd1,
        ST_BODY = 3'd2,
        ST_DROP = 3'd3,
        ST_HOLD = 3'd4
    } state_e;

endpackage

// File: rtl/ls_usb_crc_byte.sv
// One-byte CRC5/CRC16 next-state, bits consumed LSB first, fully unrolled.
module ls_usb_crc_byte
    import ls_usb_pkg::*;
(
    input  logic [7:0]  i_data,
    input  logic [4:0]  i_crc5,
    input  logic [15:0] i_crc16,
    output logic [4:0]  o_crc5,
    output logic [15:0] o_crc16
);

    logic [4:0]  w_c5;
    logic [15:0] w_c16;
    logic        w_fb5;
    logic        w_fb16;

    always_comb begin
        w_c5   = i_crc5;
        w_c16  = i_crc16;
        w_fb5  = 1'b0;
        w_fb16 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_fb5  = i_data[i] ^ w_c5[4];
            w_c5   = {w_c5[3:0], 1'b0} ^ (w_fb5 ? CRC5_POLY : 5'h00);
            w_fb16 = i_data[i] ^ w_c16[15];
            w_c16  = {w_c16[14:0], 1'b0} ^ (w_fb16 ? CRC16_POLY : 16'h0000);
        end
        o_crc5  = w_c5;
        o_crc16 = w_c16;
    end

endmodule

// File: rtl/ls_usb_rx_pkt_ctrl.sv
// Packet-level controller for the LS USB byte receiver: SYNC/PID check, body
// buffering, CRC check and classification; holds a good packet until acked.
module ls_usb_rx_pkt_ctrl
    import ls_usb_pkg::*;
#(
    parameter int         MAX_PAYLOAD = 8,
    parameter logic [7:0] SYNC_BYTE   = 8'h80
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rdata,
    input  logic       rdata_ready,
    input  logic       eop,
    input  logic       pkt_ack,
    input  logic [3:0] buf_raddr,
    output logic [7:0] buf_rdata,
    output logic       pkt_valid,
    output logic [3:0] pkt_pid,
    output logic [6:0] pkt_addr,
    output logic [3:0] pkt_endp,
    output logic [3:0] pkt_len,
    output logic       err_pulse,
    output logic [2:0] err_code,
    output logic       rx_busy
);

    localparam int         BUF_LEN  = MAX_PAYLOAD + 2;
    localparam logic [3:0] CNT_FULL = 4'(BUF_LEN);

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic                      r_eop_q;
    logic [BUF_LEN-1:0][7:0]   r_buf;
    logic [3:0]                r_cnt;
    logic [3:0]                r_pid;
    logic [4:0]                r_crc5;
    logic [15:0]               r_crc16;
    logic [4:0]                w_crc5_nxt;
    logic [15:0]               w_crc16_nxt;

    logic       w_eop_rise;
    logic       w_busy_nxt;
    logic       w_err;
    err_e       w_err_code;
    logic       w_crc_init;
    logic       w_pid_ld;
    logic       w_store;
    logic       w_accept;
    logic       w_release;
    logic [6:0] w_addr;
    logic [3:0] w_endp;
    logic [3:0] w_len;

    assign w_eop_rise = eop & ~r_eop_q;
    // End of packet beats a byte strobe in the same cycle
    assign w_busy_nxt = w_eop_rise ? 1'b0 : (rdata_ready ? 1'b1 : rx_busy);

    ls_usb_crc_byte u_crc (
        .i_data  (rdata),
        .i_crc5  (r_crc5),
        .i_crc16 (r_crc16),
        .o_crc5  (w_crc5_nxt),
        .o_crc16 (w_crc16_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_err_code  = ERR_NONE;
        w_crc_init  = 1'b0;
        w_pid_ld    = 1'b0;
        w_store     = 1'b0;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        w_addr      = 7'd0;
        w_endp      = 4'd0;
        w_len       = 4'd0;
        case (r_state)
            ST_IDLE: begin
                // A bare EOP while idle is a keep-alive, not an error
                if (!w_eop_rise && rdata_ready) begin
                    if (rdata == SYNC_BYTE) begin
                        w_state_nxt = ST_PID;
                        w_crc_init  = 1'b1;
                    end else begin
                        w_state_nxt = ST_DROP;
                        w_err       = 1'b1;
                        w_err_code  = ERR_SYNC;
                    end
                end
            end
            ST_PID: begin
                if (w_eop_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_err       = 1'b1;
                    w_err_code  = ERR_LEN;
                end else if (rdata_ready) begin
                    if (rdata[7:4] == ~rdata[3:0]) begin
                        w_state_nxt = ST_BODY;
                        w_pid_ld    = 1'b1;
                    end else begin
                        w_state_nxt = ST_DROP;
                        w_err       = 1'b1;
                        w_err_code  = ERR_PID;
                    end
                end
            end
            ST_BODY: begin
                if (w_eop_rise) begin
                    w_state_nxt = ST_IDLE;
                    case (r_pid[1:0])
                        PT_TOKEN: begin
                            w_addr = r_buf[0][6:0];
                            w_endp = {r_buf[1][2:0], r_buf[0][7]};
                            if (r_cnt != 4'd2) begin
                                w_err = 1'b1; w_err_code = ERR_LEN;
                            end else if (r_crc5 != CRC5_RESID) begin
                                w_err = 1'b1; w_err_code = ERR_CRC;
                            end else begin
                                w_accept = 1'b1;
                            end
                        end
                        PT_DATA: begin
                            w_len = r_cnt - 4'd2;
                            if (r_cnt < 4'd2) begin
                                w_err = 1'b1; w_err_code = ERR_LEN;
                            end else if (r_crc16 != CRC16_RESID) begin
                                w_err = 1'b1; w_err_code = ERR_CRC;
                            end else begin
                                w_accept = 1'b1;
                            end
                        end
                        PT_HANDSHAKE: begin
                            if (r_cnt != 4'd0) begin
                                w_err = 1'b1; w_err_code = ERR_LEN;
                            end else begin
                                w_accept = 1'b1;
                            end
                        end
                        default: begin
                            w_err = 1'b1; w_err_code = ERR_UNSUP;
                        end
                    endcase
                    if (w_accept) w_state_nxt = ST_HOLD;
                end else if (rdata_ready) begin
                    if (r_cnt == CNT_FULL) begin
                        w_state_nxt = ST_DROP;
                        w_err       = 1'b1;
                        w_err_code  = ERR_LEN;
                    end else begin
                        w_store = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (w_eop_rise) w_state_nxt = ST_IDLE;
            end
            ST_HOLD: begin
                // Only the first byte of a packet that lands on a held packet is flagged
                if (rdata_ready && !w_eop_rise && !rx_busy) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_OVERRUN;
                end
                if (pkt_ack) begin
                    w_release   = 1'b1;
                    w_state_nxt = w_busy_nxt ? ST_DROP : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eop_q   <= 1'b0;
            r_buf     <= '0;
            r_cnt     <= 4'd0;
            r_pid     <= 4'd0;
            r_crc5    <= CRC5_INIT;
            r_crc16   <= CRC16_INIT;
            pkt_valid <= 1'b0;
            pkt_pid   <= 4'd0;
            pkt_addr  <= 7'd0;
            pkt_endp  <= 4'd0;
            pkt_len   <= 4'd0;
            err_pulse <= 1'b0;
            err_code  <= 3'd0;
            rx_busy   <= 1'b0;
        end else begin
            r_eop_q   <= eop;
            rx_busy   <= w_busy_nxt;
            err_pulse <= w_err;
            if (w_err) err_code <= w_err_code;
            if (w_crc_init) begin
                r_crc5  <= CRC5_INIT;
                r_crc16 <= CRC16_INIT;
                r_cnt   <= 4'd0;
            end
            if (w_pid_ld) r_pid <= rdata[3:0];
            if (w_store) begin
                r_buf[r_cnt] <= rdata;
                r_crc5       <= w_crc5_nxt;
                r_crc16      <= w_crc16_nxt;
                r_cnt        <= r_cnt + 4'd1;
            end
            if (w_accept) begin
                pkt_valid <= 1'b1;
                pkt_pid   <= r_pid;
                pkt_addr  <= w_addr;
                pkt_endp  <= w_endp;
                pkt_len   <= w_len;
            end else if (w_release) begin
                pkt_valid <= 1'b0;
            end
        end
    end

    // Reads past pkt_len return whatever the buffer last held
    always_comb begin
        buf_rdata = 8'h00;
        if (int'(buf_raddr) < BUF_LEN) buf_rdata = r_buf[buf_raddr];
    end

endmodule

// File: tb/tb_ls_usb_rx_pkt_ctrl.sv
// Scoreboard bench for ls_usb_rx_pkt_ctrl: directed packets push expected
// results; a negedge monitor pops them as pkt_valid rises or err_pulse fires.
module tb_ls_usb_rx_pkt_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rdata = 8'h00;
    logic       rdata_ready = 1'b0;
    logic       eop = 1'b0;
    logic       pkt_ack = 1'b0;
    logic [3:0] buf_raddr = 4'd0;
    logic [7:0] buf_rdata;
    logic       pkt_valid;
    logic [3:0] pkt_pid;
    logic [6:0] pkt_addr;
    logic [3:0] pkt_endp;
    logic [3:0] pkt_len;
    logic       err_pulse;
    logic [2:0] err_code;
    logic       rx_busy;

    ls_usb_rx_pkt_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rdata(rdata), .rdata_ready(rdata_ready),
        .eop(eop), .pkt_ack(pkt_ack), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
        .pkt_valid(pkt_valid), .pkt_pid(pkt_pid), .pkt_addr(pkt_addr),
        .pkt_endp(pkt_endp), .pkt_len(pkt_len), .err_pulse(err_pulse),
        .err_code(err_code), .rx_busy(rx_busy)
    );

    always #100 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [2:0] code;
        logic [3:0] pid;
        logic [6:0] addr;
        logic [3:0] endp;
        logic [3:0] len;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] seq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       prev_v = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic exp_pkt(input logic [3:0] pid, input logic [6:0] addr,
                           input logic [3:0] endp, input logic [3:0] len);
        exp_t e;
        e.is_err = 1'b0; e.code = 3'd0; e.pid = pid; e.addr = addr; e.endp = endp; e.len = len;
        sb.push_back(e);
    endtask

    task automatic exp_err(input logic [2:0] code);
        exp_t e;
        e.is_err = 1'b1; e.code = code; e.pid = 4'd0; e.addr = 7'd0; e.endp = 4'd0; e.len = 4'd0;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_seq();
        foreach (seq[i]) begin
            rdata = seq[i];
            rdata_ready = 1'b1;
            tick();
            rdata_ready = 1'b0;
        end
    endtask

    task automatic send_eop();
        eop = 1'b1;
        tick();
        tick();
        eop = 1'b0;
        tick();
    endtask

    task automatic ack();
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
    endtask

    // Monitor: pop one expectation per DUT event
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (err_pulse) begin
                if (sb.size() == 0) chk("unexpected_err", {29'd0, err_code}, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("event_is_err", 32'd1, {31'd0, e.is_err});
                    chk("err_code", {29'd0, err_code}, {29'd0, e.code});
                end
            end
            if (pkt_valid && !prev_v) begin
                if (sb.size() == 0) chk("unexpected_pkt", {28'd0, pkt_pid}, 32'hFFFF_FFFF);
                else begin
                    e = sb.pop_front();
                    chk("event_is_pkt", 32'd0, {31'd0, e.is_err});
                    chk("pkt_pid", {28'd0, pkt_pid}, {28'd0, e.pid});
                    chk("pkt_addr", {25'd0, pkt_addr}, {25'd0, e.addr});
                    chk("pkt_endp", {28'd0, pkt_endp}, {28'd0, e.endp});
                    chk("pkt_len", {28'd0, pkt_len}, {28'd0, e.len});
                end
            end
            prev_v = pkt_valid;
        end
    end

    initial begin
        // Reset state
        #50;
        chk("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
        chk("rst_err_code", {29'd0, err_code}, 32'd0);
        chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
        chk("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
        chk("rst_buf_rdata", {24'd0, buf_rdata}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // SETUP addr 0 endp 0, with N+1 latency and hold until ack
        exp_pkt(4'hD, 7'd0, 4'd0, 4'd0);
        seq = '{8'h80, 8'h2D, 8'h00, 8'h10};
        send_seq();
        chk("busy_mid_pkt", {31'd0, rx_busy}, 32'd1);
        eop = 1'b1;
        tick();
        chk("latency_valid", {31'd0, pkt_valid}, 32'd1);
        tick();
        eop = 1'b0;
        repeat (5) tick();
        chk("held_valid", {31'd0, pkt_valid}, 32'd1);
        chk("busy_after_eop", {31'd0, rx_busy}, 32'd0);
        ack();
        chk("ack_clears_valid", {31'd0, pkt_valid}, 32'd0);

        // DATA0 8-byte GET_DESCRIPTOR payload
        exp_pkt(4'h3, 7'd0, 4'd0, 4'd8);
        seq = '{8'h80, 8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        send_seq();
        send_eop();
        buf_raddr = 4'd1; #1;
        chk("buf_rdata_1", {24'd0, buf_rdata}, 32'h06);
        buf_raddr = 4'd0; #1;
        chk("buf_rdata_0", {24'd0, buf_rdata}, 32'h80);
        buf_raddr = 4'd6; #1;
        chk("buf_rdata_6", {24'd0, buf_rdata}, 32'h40);
        ack();

        // ACK handshake, then bad PID check
        exp_pkt(4'h2, 7'd0, 4'd0, 4'd0);
        seq = '{8'h80, 8'hD2};
        send_seq();
        send_eop();
        ack();
        exp_err(3'd2);
        seq = '{8'h80, 8'h2C};
        send_seq();
        send_eop();

        // Bad CRC16, then body overflow
        exp_err(3'd3);
        seq = '{8'h80, 8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h95};
        send_seq();
        send_eop();
        exp_err(3'd4);
        seq = '{8'h80, 8'hC3, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        send_seq();
        send_eop();
        repeat (3) tick();
        chk("err_code_held", {29'd0, err_code}, 32'd4);

        // Bad SYNC, special PID, short token, EOP right after SYNC, idle keep-alive EOP
        exp_err(3'd1);
        seq = '{8'h55, 8'h2D};
        send_seq();
        send_eop();
        exp_err(3'd5);
        seq = '{8'h80, 8'h3C};
        send_seq();
        send_eop();
        exp_err(3'd4);
        seq = '{8'h80, 8'hE1, 8'h00};
        send_seq();
        send_eop();
        exp_err(3'd4);
        seq = '{8'h80};
        send_seq();
        send_eop();
        send_eop();

        // IN addr 0x15 endp 0xE held; overrun packet must not disturb it
        exp_pkt(4'h9, 7'h15, 4'hE, 4'd0);
        seq = '{8'h80, 8'h69, 8'h15, 8'hEF};
        send_seq();
        send_eop();
        exp_err(3'd6);
        seq = '{8'h80, 8'h2D, 8'h00, 8'h10};
        send_seq();
        send_eop();
        chk("hold_valid", {31'd0, pkt_valid}, 32'd1);
        chk("hold_pid", {28'd0, pkt_pid}, 32'h9);
        chk("hold_addr", {25'd0, pkt_addr}, 32'h15);
        chk("hold_endp", {28'd0, pkt_endp}, 32'hE);
        buf_raddr = 4'd0; #1;
        chk("hold_buf0", {24'd0, buf_rdata}, 32'h15);

        // Ack mid-packet: the rest of that packet is dropped silently
        exp_err(3'd6);
        seq = '{8'h80, 8'h2D};
        send_seq();
        ack();
        chk("ack_mid_valid", {31'd0, pkt_valid}, 32'd0);
        seq = '{8'h00, 8'h10};
        send_seq();
        send_eop();
        exp_pkt(4'hD, 7'd0, 4'd0, 4'd0);
        seq = '{8'h80, 8'h2D, 8'h00, 8'h10};
        send_seq();
        send_eop();
        ack();
        chk("err_code_after_drop", {29'd0, err_code}, 32'd6);

        // Asynchronous reset in the middle of a body
        seq = '{8'h80, 8'hC3, 8'h80, 8'h06};
        send_seq();
        buf_raddr = 4'd0;
        #40;
        rst_n = 1'b0;
        #5;
        chk("arst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
        chk("arst_pkt_pid", {28'd0, pkt_pid}, 32'd0);
        chk("arst_err_code", {29'd0, err_code}, 32'd0);
        chk("arst_rx_busy", {31'd0, rx_busy}, 32'd0);
        chk("arst_buf_rdata", {24'd0, buf_rdata}, 32'd0);
        #150;
        rst_n = 1'b1;
        tick();
        exp_pkt(4'h3, 7'd0, 4'd0, 4'd8);
        seq = '{8'h80, 8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        send_seq();
        send_eop();
        buf_raddr = 4'd3; #1;
        chk("post_rst_buf3", {24'd0, buf_rdata}, 32'h01);
        ack();
        repeat (4) tick();

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_event: got none expected is_err=%0d code=%0d pid=0x%0h",
                     e.is_err, e.code, e.pid);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
